// File: rtl/jelly_rr_arbiter_select.sv
// ---------------------------------------------------------------------------
// jelly_rr_arbiter_select
//   Combinational round-robin priority select. The search starts at ptr and
//   wraps modulo NUM; the first asserted request wins. Usable by both the
//   read-side and write-side AXI4 arbiters.
//
// Ports:
//   request [NUM-1:0]        request vector, one bit per requester
//   ptr     [SEL_WIDTH-1:0]  highest-priority index for this search
//   valid                    at least one request is asserted
//   index   [SEL_WIDTH-1:0]  winning requester (0 when valid=0)
// ---------------------------------------------------------------------------
module jelly_rr_arbiter_select #(
  parameter int NUM       = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [NUM-1:0]       request,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 valid,
  output logic [SEL_WIDTH-1:0] index
);

  int                   pos;
  logic [SEL_WIDTH-1:0] pos_idx;

  // Walk from the farthest offset down to offset 0 so that the candidate
  // closest to ptr is the last to write, and therefore wins.
  always_comb begin
    valid   = 1'b0;
    index   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM) begin
        pos = pos - NUM;
      end
      pos_idx = SEL_WIDTH'(pos);
      if (request[pos_idx]) begin
        valid = 1'b1;
        index = pos_idx;
      end
    end
  end

endmodule

// File: rtl/jelly_axi4_write_arbiter.sv
// ---------------------------------------------------------------------------
// jelly_axi4_write_arbiter
//   Shares one AXI4 write master port between NUM requester slave ports with
//   round-robin arbitration. One transaction is in flight at a time: the
//   granted requester's AW, its full W burst (ended by wlast), then B.
//   Requester i occupies slice [i*W +: W] of every flat per-requester vector.
//
// Handshake semantics: a beat transfers on a rising aclk edge where valid and
// ready are both 1. Payload is taken from the registered selection only, so
// no requester valid reaches any ready combinationally; valid never waits on
// ready at this block.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   s_axi4_aw*              per-requester write address channels
//   s_axi4_w*               per-requester write data channels
//   s_axi4_b*               per-requester write response channels
//                           (bid/bresp broadcast, bvalid only on selected)
//   m_axi4_aw*/w*/b*        shared master port toward the write sink
//   dbg_state               FSM state (0 IDLE, 1 BUSY, 2 RESP)
//   dbg_sel, dbg_rr_ptr     current grant and round-robin pointer
// ---------------------------------------------------------------------------
module jelly_axi4_write_arbiter #(
  parameter int NUM             = 4,
  parameter int SEL_WIDTH       = 2,
  parameter int AXI4_ID_WIDTH   = 6,
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8,
  parameter int AXI4_LEN_WIDTH  = 8
) (
  input  logic                                 aclk,
  input  logic                                 areset,

  input  logic [NUM*AXI4_ID_WIDTH-1:0]         s_axi4_awid,
  input  logic [NUM*AXI4_ADDR_WIDTH-1:0]       s_axi4_awaddr,
  input  logic [NUM*AXI4_LEN_WIDTH-1:0]        s_axi4_awlen,
  input  logic [NUM*3-1:0]                     s_axi4_awsize,
  input  logic [NUM*2-1:0]                     s_axi4_awburst,
  input  logic [NUM*4-1:0]                     s_axi4_awcache,
  input  logic [NUM*3-1:0]                     s_axi4_awprot,
  input  logic [NUM-1:0]                       s_axi4_awvalid,
  output logic [NUM-1:0]                       s_axi4_awready,
  input  logic [NUM*AXI4_DATA_WIDTH-1:0]       s_axi4_wdata,
  input  logic [NUM*AXI4_STRB_WIDTH-1:0]       s_axi4_wstrb,
  input  logic [NUM-1:0]                       s_axi4_wlast,
  input  logic [NUM-1:0]                       s_axi4_wvalid,
  output logic [NUM-1:0]                       s_axi4_wready,
  output logic [NUM*AXI4_ID_WIDTH-1:0]         s_axi4_bid,
  output logic [NUM*2-1:0]                     s_axi4_bresp,
  output logic [NUM-1:0]                       s_axi4_bvalid,
  input  logic [NUM-1:0]                       s_axi4_bready,

  output logic [AXI4_ID_WIDTH-1:0]             m_axi4_awid,
  output logic [AXI4_ADDR_WIDTH-1:0]           m_axi4_awaddr,
  output logic [AXI4_LEN_WIDTH-1:0]            m_axi4_awlen,
  output logic [2:0]                           m_axi4_awsize,
  output logic [1:0]                           m_axi4_awburst,
  output logic [3:0]                           m_axi4_awcache,
  output logic [2:0]                           m_axi4_awprot,
  output logic                                 m_axi4_awvalid,
  input  logic                                 m_axi4_awready,
  output logic [AXI4_DATA_WIDTH-1:0]           m_axi4_wdata,
  output logic [AXI4_STRB_WIDTH-1:0]           m_axi4_wstrb,
  output logic                                 m_axi4_wlast,
  output logic                                 m_axi4_wvalid,
  input  logic                                 m_axi4_wready,
  input  logic [AXI4_ID_WIDTH-1:0]             m_axi4_bid,
  input  logic [1:0]                           m_axi4_bresp,
  input  logic                                 m_axi4_bvalid,
  output logic                                 m_axi4_bready,

  output logic [1:0]                           dbg_state,
  output logic [SEL_WIDTH-1:0]                 dbg_sel,
  output logic [SEL_WIDTH-1:0]                 dbg_rr_ptr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]           state;
  logic [SEL_WIDTH-1:0] sel;
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic                 aw_done;
  logic                 w_done;

  logic                 arb_valid;
  logic [SEL_WIDTH-1:0] arb_index;

  logic                 busy;
  logic                 resp;
  logic                 aw_hs;
  logic                 w_last_hs;
  logic                 b_hs;

  jelly_rr_arbiter_select #(
    .NUM       (NUM),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_select (
    .request (s_axi4_awvalid),
    .ptr     (rr_ptr),
    .valid   (arb_valid),
    .index   (arb_index)
  );

  assign busy = (state == ST_BUSY);
  assign resp = (state == ST_RESP);

  // Payload muxes follow the registered selection in every state; only the
  // valid/ready qualifiers depend on the state.
  always_comb begin
    m_axi4_awid    = s_axi4_awid   [int'(sel)*AXI4_ID_WIDTH   +: AXI4_ID_WIDTH];
    m_axi4_awaddr  = s_axi4_awaddr [int'(sel)*AXI4_ADDR_WIDTH +: AXI4_ADDR_WIDTH];
    m_axi4_awlen   = s_axi4_awlen  [int'(sel)*AXI4_LEN_WIDTH  +: AXI4_LEN_WIDTH];
    m_axi4_awsize  = s_axi4_awsize [int'(sel)*3 +: 3];
    m_axi4_awburst = s_axi4_awburst[int'(sel)*2 +: 2];
    m_axi4_awcache = s_axi4_awcache[int'(sel)*4 +: 4];
    m_axi4_awprot  = s_axi4_awprot [int'(sel)*3 +: 3];
    m_axi4_wdata   = s_axi4_wdata  [int'(sel)*AXI4_DATA_WIDTH +: AXI4_DATA_WIDTH];
    m_axi4_wstrb   = s_axi4_wstrb  [int'(sel)*AXI4_STRB_WIDTH +: AXI4_STRB_WIDTH];
    m_axi4_wlast   = s_axi4_wlast[sel];
  end

  // The done flags stop a second AW or extra W beats from leaking out while
  // the other channel of the same transaction is still in progress.
  assign m_axi4_awvalid = busy & s_axi4_awvalid[sel] & ~aw_done;
  assign m_axi4_wvalid  = busy & s_axi4_wvalid[sel]  & ~w_done;
  assign m_axi4_bready  = resp & s_axi4_bready[sel];

  always_comb begin
    s_axi4_awready = '0;
    s_axi4_wready  = '0;
    s_axi4_bvalid  = '0;
    if (busy) begin
      s_axi4_awready[sel] = m_axi4_awready & ~aw_done;
      s_axi4_wready[sel]  = m_axi4_wready  & ~w_done;
    end
    if (resp) begin
      s_axi4_bvalid[sel] = m_axi4_bvalid;
    end
  end

  assign s_axi4_bid   = {NUM{m_axi4_bid}};
  assign s_axi4_bresp = {NUM{m_axi4_bresp}};

  assign aw_hs     = m_axi4_awvalid & m_axi4_awready;
  assign w_last_hs = m_axi4_wvalid & m_axi4_wready & m_axi4_wlast;
  assign b_hs      = m_axi4_bvalid & m_axi4_bready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= ST_IDLE;
      sel     <= '0;
      rr_ptr  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            sel    <= arb_index;
            rr_ptr <= (arb_index == SEL_WIDTH'(NUM - 1)) ? '0 : arb_index + 1'b1;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Both channels may finish in the same cycle; the flags are cleared
          // on exit so the next transaction starts clean.
          if ((aw_done | aw_hs) && (w_done | w_last_hs)) begin
            state   <= ST_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_done <= 1'b1;
            end
            if (w_last_hs) begin
              w_done <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (b_hs) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dbg_state  = state;
  assign dbg_sel    = sel;
  assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_jelly_axi4_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_jelly_axi4_write_arbiter
//   Directed bench for the AXI4 write arbiter with NUM=4 and a 32-bit data
//   path. Inputs change on the falling edge; outputs are checked 1 time unit
//   later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_jelly_axi4_write_arbiter;

  localparam int NUM = 4;
  localparam int SW  = 2;
  localparam int IDW = 6;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SB  = DW / 8;
  localparam int LW  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // ---------------- clock / reset ----------------
  logic aclk;
  logic areset;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- DUT signals ----------------
  logic [NUM*IDW-1:0] s_axi4_awid;
  logic [NUM*AW-1:0]  s_axi4_awaddr;
  logic [NUM*LW-1:0]  s_axi4_awlen;
  logic [NUM*3-1:0]   s_axi4_awsize;
  logic [NUM*2-1:0]   s_axi4_awburst;
  logic [NUM*4-1:0]   s_axi4_awcache;
  logic [NUM*3-1:0]   s_axi4_awprot;
  logic [NUM-1:0]     s_axi4_awvalid;
  logic [NUM-1:0]     s_axi4_awready;
  logic [NUM*DW-1:0]  s_axi4_wdata;
  logic [NUM*SB-1:0]  s_axi4_wstrb;
  logic [NUM-1:0]     s_axi4_wlast;
  logic [NUM-1:0]     s_axi4_wvalid;
  logic [NUM-1:0]     s_axi4_wready;
  logic [NUM*IDW-1:0] s_axi4_bid;
  logic [NUM*2-1:0]   s_axi4_bresp;
  logic [NUM-1:0]     s_axi4_bvalid;
  logic [NUM-1:0]     s_axi4_bready;

  logic [IDW-1:0]     m_axi4_awid;
  logic [AW-1:0]      m_axi4_awaddr;
  logic [LW-1:0]      m_axi4_awlen;
  logic [2:0]         m_axi4_awsize;
  logic [1:0]         m_axi4_awburst;
  logic [3:0]         m_axi4_awcache;
  logic [2:0]         m_axi4_awprot;
  logic               m_axi4_awvalid;
  logic               m_axi4_awready;
  logic [DW-1:0]      m_axi4_wdata;
  logic [SB-1:0]      m_axi4_wstrb;
  logic               m_axi4_wlast;
  logic               m_axi4_wvalid;
  logic               m_axi4_wready;
  logic [IDW-1:0]     m_axi4_bid;
  logic [1:0]         m_axi4_bresp;
  logic               m_axi4_bvalid;
  logic               m_axi4_bready;

  logic [1:0]         dbg_state;
  logic [SW-1:0]      dbg_sel;
  logic [SW-1:0]      dbg_rr_ptr;

  jelly_axi4_write_arbiter #(
    .NUM             (NUM),
    .SEL_WIDTH       (SW),
    .AXI4_ID_WIDTH   (IDW),
    .AXI4_ADDR_WIDTH (AW),
    .AXI4_DATA_WIDTH (DW),
    .AXI4_STRB_WIDTH (SB),
    .AXI4_LEN_WIDTH  (LW)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_axi4_awid    (s_axi4_awid),
    .s_axi4_awaddr  (s_axi4_awaddr),
    .s_axi4_awlen   (s_axi4_awlen),
    .s_axi4_awsize  (s_axi4_awsize),
    .s_axi4_awburst (s_axi4_awburst),
    .s_axi4_awcache (s_axi4_awcache),
    .s_axi4_awprot  (s_axi4_awprot),
    .s_axi4_awvalid (s_axi4_awvalid),
    .s_axi4_awready (s_axi4_awready),
    .s_axi4_wdata   (s_axi4_wdata),
    .s_axi4_wstrb   (s_axi4_wstrb),
    .s_axi4_wlast   (s_axi4_wlast),
    .s_axi4_wvalid  (s_axi4_wvalid),
    .s_axi4_wready  (s_axi4_wready),
    .s_axi4_bid     (s_axi4_bid),
    .s_axi4_bresp   (s_axi4_bresp),
    .s_axi4_bvalid  (s_axi4_bvalid),
    .s_axi4_bready  (s_axi4_bready),
    .m_axi4_awid    (m_axi4_awid),
    .m_axi4_awaddr  (m_axi4_awaddr),
    .m_axi4_awlen   (m_axi4_awlen),
    .m_axi4_awsize  (m_axi4_awsize),
    .m_axi4_awburst (m_axi4_awburst),
    .m_axi4_awcache (m_axi4_awcache),
    .m_axi4_awprot  (m_axi4_awprot),
    .m_axi4_awvalid (m_axi4_awvalid),
    .m_axi4_awready (m_axi4_awready),
    .m_axi4_wdata   (m_axi4_wdata),
    .m_axi4_wstrb   (m_axi4_wstrb),
    .m_axi4_wlast   (m_axi4_wlast),
    .m_axi4_wvalid  (m_axi4_wvalid),
    .m_axi4_wready  (m_axi4_wready),
    .m_axi4_bid     (m_axi4_bid),
    .m_axi4_bresp   (m_axi4_bresp),
    .m_axi4_bvalid  (m_axi4_bvalid),
    .m_axi4_bready  (m_axi4_bready),
    .dbg_state      (dbg_state),
    .dbg_sel        (dbg_sel),
    .dbg_rr_ptr     (dbg_rr_ptr)
  );

  // ---------------- check bookkeeping ----------------
  int checks_total  = 0;
  int checks_passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [NUM-1:0] onehot(input int p);
    logic [NUM-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] beat_data(input int port, input int beat);
    return DW'(32'hA500_0000 | (port << 8) | beat);
  endfunction

  function automatic logic [DW-1:0] junk_data(input int beat);
    return DW'(32'hDEAD_0000 | beat);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    s_axi4_awid    = '0;
    s_axi4_awaddr  = '0;
    s_axi4_awlen   = '0;
    s_axi4_awsize  = '0;
    s_axi4_awburst = '0;
    s_axi4_awcache = '0;
    s_axi4_awprot  = '0;
    s_axi4_awvalid = '0;
    s_axi4_wdata   = '0;
    s_axi4_wstrb   = '0;
    s_axi4_wlast   = '0;
    s_axi4_wvalid  = '0;
    s_axi4_bready  = '0;
    m_axi4_awready = 1'b0;
    m_axi4_wready  = 1'b0;
    m_axi4_bid     = '0;
    m_axi4_bresp   = '0;
    m_axi4_bvalid  = 1'b0;
  endtask

  task automatic set_aw(input int port, input logic [IDW-1:0] id,
                        input logic [AW-1:0] addr, input logic [LW-1:0] len);
    s_axi4_awid   [port*IDW +: IDW] = id;
    s_axi4_awaddr [port*AW  +: AW]  = addr;
    s_axi4_awlen  [port*LW  +: LW]  = len;
    s_axi4_awsize [port*3   +: 3]   = 3'd2;
    s_axi4_awburst[port*2   +: 2]   = 2'b01;
    s_axi4_awcache[port*4   +: 4]   = 4'h3;
    s_axi4_awprot [port*3   +: 3]   = 3'b000;
    s_axi4_awvalid[port]            = 1'b1;
  endtask

  task automatic set_w(input int port, input logic [DW-1:0] data,
                       input logic last, input logic valid);
    s_axi4_wdata [port*DW +: DW] = data;
    s_axi4_wstrb [port*SB +: SB] = '1;
    s_axi4_wlast [port]          = last;
    s_axi4_wvalid[port]          = valid;
  endtask

  // One complete transaction on a single requester, entered and left on a
  // falling edge with the arbiter idle. The requester keeps awvalid high and
  // keeps offering junk W beats after its last beat, so any duplicate AW or
  // extra W beat shows up on the master side. Expected state per cycle:
  // cycle 0 IDLE, cycles 1..exp_busy BUSY, then RESP until the B handshake.
  task automatic run_txn(input int port, input logic [IDW-1:0] id,
                         input logic [AW-1:0] addr, input int nbeats,
                         input int aw_hold, input bit w_toggle, input int b_hold,
                         input logic [1:0] resp, input int exp_busy);
    int         aw_m;
    int         w_m;
    int         b_s;
    int         req_beat;
    int         bhold_left;
    int         other;
    bit         sink_aw;
    bit         done;
    bit         req_w_hs;
    logic [1:0] exp_st;

    aw_m       = 0;
    w_m        = 0;
    b_s        = 0;
    req_beat   = 0;
    bhold_left = b_hold;
    other      = (port + 1) % NUM;
    sink_aw    = 1'b0;
    done       = 1'b0;

    set_aw(port, id, addr, LW'(nbeats - 1));
    set_w(port, beat_data(port, 0), nbeats == 1, 1'b1);

    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      m_axi4_awready       = (cyc >= aw_hold);
      m_axi4_wready        = w_toggle ? cyc[0] : 1'b1;
      m_axi4_bvalid        = sink_aw && (w_m == nbeats);
      m_axi4_bid           = id;
      m_axi4_bresp         = resp;
      s_axi4_bready[port]  = (bhold_left == 0);
      #1;
      exp_st = (cyc == 0) ? ST_IDLE : (cyc <= exp_busy) ? ST_BUSY : ST_RESP;
      chk("state", dbg_state, exp_st);
      chk("m_bready", m_axi4_bready, exp_st == ST_RESP && s_axi4_bready[port]);
      chk("s_bvalid", s_axi4_bvalid,
          (exp_st == ST_RESP && m_axi4_bvalid) ? onehot(port) : '0);
      if (exp_st == ST_IDLE) begin
        chk("idle_awready", s_axi4_awready, '0);
        chk("idle_wready", s_axi4_wready, '0);
      end
      if (m_axi4_awvalid && m_axi4_awready) begin
        aw_m++;
        chk("awaddr", m_axi4_awaddr, addr);
        chk("awid", m_axi4_awid, id);
        chk("awlen", m_axi4_awlen, LW'(nbeats - 1));
        chk("awsize", m_axi4_awsize, 3'd2);
        sink_aw = 1'b1;
      end
      if (m_axi4_wvalid && m_axi4_wready) begin
        chk("wdata", m_axi4_wdata, beat_data(port, w_m));
        chk("wlast", m_axi4_wlast, w_m == nbeats - 1);
        w_m++;
      end
      if (exp_st == ST_RESP && m_axi4_bvalid) begin
        chk("bid_sel", s_axi4_bid[port*IDW +: IDW], id);
        chk("bid_bcast", s_axi4_bid[other*IDW +: IDW], id);
        chk("bresp", s_axi4_bresp[port*2 +: 2], resp);
        if (s_axi4_bready[port]) begin
          b_s++;
          done = 1'b1;
        end else begin
          bhold_left--;
        end
      end
      req_w_hs = s_axi4_wready[port] && s_axi4_wvalid[port];
      @(negedge aclk);
      if (req_w_hs) begin
        req_beat++;
        if (req_beat < nbeats) begin
          set_w(port, beat_data(port, req_beat), req_beat == nbeats - 1, 1'b1);
        end else begin
          set_w(port, junk_data(req_beat), 1'b0, 1'b1);
        end
      end
    end

    chk("txn_done", done, 1'b1);
    chk("aw_count", aw_m, 1);
    chk("w_count", w_m, nbeats);
    chk("b_count", b_s, 1);

    m_axi4_bvalid        = 1'b0;
    m_axi4_awready       = 1'b0;
    m_axi4_wready        = 1'b0;
    s_axi4_awvalid[port] = 1'b0;
    s_axi4_wvalid[port]  = 1'b0;
    s_axi4_bready[port]  = 1'b0;
    #1;
    chk("back_idle", dbg_state, ST_IDLE);
    @(negedge aclk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0] exp_st;
    int         g;

    clear_inputs();
    areset = 1'b1;
    // Requests and sink readiness are active during reset; reset dominates.
    set_aw(2, 6'h05, 32'h0000_1000, 8'd3);
    set_w(2, beat_data(2, 0), 1'b0, 1'b1);
    m_axi4_awready = 1'b1;
    m_axi4_wready  = 1'b1;
    m_axi4_bvalid  = 1'b1;
    s_axi4_bready  = '1;
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_rr_ptr", dbg_rr_ptr, 2'd0);
    chk("rst_sel", dbg_sel, 2'd0);
    chk("rst_m_awvalid", m_axi4_awvalid, 1'b0);
    chk("rst_m_wvalid", m_axi4_wvalid, 1'b0);
    chk("rst_m_bready", m_axi4_bready, 1'b0);
    chk("rst_s_awready", s_axi4_awready, '0);
    chk("rst_s_wready", s_axi4_wready, '0);
    chk("rst_s_bvalid", s_axi4_bvalid, '0);
    @(negedge aclk);
    areset = 1'b0;
    clear_inputs();
    @(negedge aclk);

    // Single requester, 4 beats, sink always ready.
    run_txn(2, 6'h05, 32'h0000_1000, 4, 0, 1'b0, 0, 2'b00, 4);
    chk("rr_after_p2", dbg_rr_ptr, 2'd3);

    // wready toggling on an 8-beat burst, B held off for 3 cycles.
    run_txn(3, 6'h11, 32'h0000_3000, 8, 0, 1'b1, 3, 2'b01, 15);
    chk("rr_after_p3", dbg_rr_ptr, 2'd0);

    // W finishes before AW: awready held low through BUSY cycles 1..5.
    run_txn(1, 6'h22, 32'h0000_5000, 2, 6, 1'b0, 0, 2'b00, 6);
    chk("rr_after_p1", dbg_rr_ptr, 2'd2);

    // AW and the last W beat complete on the same edge.
    run_txn(0, 6'h33, 32'h0000_7000, 2, 2, 1'b0, 0, 2'b11, 2);
    chk("rr_after_p0", dbg_rr_ptr, 2'd1);

    // Reset after 2 of 4 beats on port 1.
    set_aw(1, 6'h0A, 32'h0000_9000, 8'd3);
    set_w(1, beat_data(1, 0), 1'b0, 1'b1);
    m_axi4_awready = 1'b1;
    m_axi4_wready  = 1'b1;
    @(negedge aclk);                       // granted, now BUSY
    @(negedge aclk);                       // AW + beat 0 taken
    set_w(1, beat_data(1, 1), 1'b0, 1'b1);
    @(negedge aclk);                       // beat 1 taken
    set_w(1, beat_data(1, 2), 1'b0, 1'b1);
    areset = 1'b1;
    @(negedge aclk);
    #1;
    chk("mid_rst_state", dbg_state, ST_IDLE);
    chk("mid_rst_rr_ptr", dbg_rr_ptr, 2'd0);
    chk("mid_rst_m_awvalid", m_axi4_awvalid, 1'b0);
    chk("mid_rst_m_wvalid", m_axi4_wvalid, 1'b0);
    chk("mid_rst_s_awready", s_axi4_awready, '0);
    chk("mid_rst_s_wready", s_axi4_wready, '0);
    chk("mid_rst_m_bready", m_axi4_bready, 1'b0);
    @(negedge aclk);
    areset = 1'b0;
    clear_inputs();
    @(negedge aclk);
    run_txn(3, 6'h3C, 32'h0000_B000, 1, 0, 1'b0, 0, 2'b00, 1);
    chk("rr_wrap", dbg_rr_ptr, 2'd0);

    // Round-robin: all ports request continuously with 1-beat bursts and the
    // sink keeps bvalid high. Period is IDLE, BUSY, RESP; grants 0,1,2,3,0.
    for (int p = 0; p < NUM; p++) begin
      set_aw(p, IDW'(8 + p), AW'(32'h2000 + p * 32'h100), 8'd0);
      set_w(p, beat_data(p, 0), 1'b1, 1'b1);
    end
    s_axi4_bready  = '1;
    m_axi4_awready = 1'b1;
    m_axi4_wready  = 1'b1;
    m_axi4_bvalid  = 1'b1;
    m_axi4_bid     = 6'h2A;
    m_axi4_bresp   = 2'b10;
    for (int c = 0; c < 15; c++) begin
      #1;
      exp_st = (c % 3 == 0) ? ST_IDLE : (c % 3 == 1) ? ST_BUSY : ST_RESP;
      g      = (c / 3) % NUM;
      chk("rr_state", dbg_state, exp_st);
      if (exp_st == ST_IDLE) begin
        chk("rr_idle_awready", s_axi4_awready, '0);
      end
      if (exp_st == ST_BUSY) begin
        chk("rr_awready", s_axi4_awready, onehot(g));
        chk("rr_wready", s_axi4_wready, onehot(g));
        chk("rr_awaddr", m_axi4_awaddr, AW'(32'h2000 + g * 32'h100));
        chk("rr_b_held", m_axi4_bready, 1'b0);
      end
      if (exp_st == ST_RESP) begin
        chk("rr_bvalid", s_axi4_bvalid, onehot(g));
        chk("rr_bready", m_axi4_bready, 1'b1);
        chk("rr_bid", s_axi4_bid[g*IDW +: IDW], 6'h2A);
      end
      @(negedge aclk);
    end
    clear_inputs();
    #1;
    chk("rr_end_idle", dbg_state, ST_IDLE);
    @(negedge aclk);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
